// File: rtl/coder_scan.sv
// Priority encoder with a captured-digit shift buffer and a multiplexed seven-segment scanner.
// Define CODER_SCAN_BLANK_EN to blank digits that have not been written since the last clear.
module coder_scan #(
  parameter int DIN_W    = 10,
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             seltype,
  input  logic [DIN_W-1:0] din1,
  input  logic             clr,
  output logic             flag,
  output logic [3:0]       ledout,
  output logic [3:0]       count,
  output logic [6:0]       ssdout,
  output logic             dp,
  output logic [7:0]       an
);

  localparam int             PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [2:0]     DIG_MAX   = 3'(DIGITS - 1);
  localparam logic [3:0]     COUNT_MAX = 4'(DIGITS);

  logic                    flag_q, flag_d;
  logic [3:0]              ledout_q, ledout_d;
  logic                    flag_prev_q, flag_prev_d;
  logic                    armed_q, armed_d;
  logic [3:0]              count_q, count_d;
  logic [DIGITS-1:0][3:0]  digits_q, digits_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [2:0]              dig_q, dig_d;
`ifdef CODER_SCAN_BLANK_EN
  logic [DIGITS-1:0]       valid_q, valid_d;
`endif

  logic [3:0] enc_idx;
  logic       enc_hit;
  logic       capture;
  logic [3:0] cur_digit;
  logic       cur_on;
  logic [6:0] seg;

  // Ascending scan: in high mode every set bit overwrites, in low mode only the first one sticks.
  always_comb begin
    enc_idx = '0;
    enc_hit = 1'b0;
    for (int i = 0; i < DIN_W; i++) begin
      if (din1[i]) begin
        if (seltype || !enc_hit) enc_idx = 4'(i);
        enc_hit = 1'b1;
      end
    end
  end

  // armed stays low after reset until the encoder goes idle, so a request held through reset cannot capture.
  always_comb begin
    flag_d      = enable & enc_hit;
    ledout_d    = flag_d ? enc_idx : 4'd0;
    flag_prev_d = flag_q;
    armed_d     = armed_q | ~flag_d;
    capture     = flag_q & ~flag_prev_q & armed_q;
  end

  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
`ifdef CODER_SCAN_BLANK_EN
    valid_d  = valid_q;
`endif
    if (clr) begin
      digits_d = '0;
      count_d  = 4'd0;
`ifdef CODER_SCAN_BLANK_EN
      valid_d  = '0;
`endif
    end else if (capture) begin
      digits_d[0] = ledout_q;
      for (int k = 1; k < DIGITS; k++) digits_d[k] = digits_q[k-1];
      if (count_q < COUNT_MAX) count_d = count_q + 4'd1;
`ifdef CODER_SCAN_BLANK_EN
      valid_d[0] = 1'b1;
      for (int k = 1; k < DIGITS; k++) valid_d[k] = valid_q[k-1];
`endif
    end
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    dig_d   = dig_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      dig_d   = (dig_q == DIG_MAX) ? 3'd0 : dig_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q      <= 1'b0;
      ledout_q    <= 4'd0;
      flag_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      count_q     <= 4'd0;
      digits_q    <= '0;
      presc_q     <= '0;
      dig_q       <= 3'd0;
`ifdef CODER_SCAN_BLANK_EN
      valid_q     <= '0;
`endif
    end else begin
      flag_q      <= flag_d;
      ledout_q    <= ledout_d;
      flag_prev_q <= flag_prev_d;
      armed_q     <= armed_d;
      count_q     <= count_d;
      digits_q    <= digits_d;
      presc_q     <= presc_d;
      dig_q       <= dig_d;
`ifdef CODER_SCAN_BLANK_EN
      valid_q     <= valid_d;
`endif
    end
  end

  // Display path is purely combinational from dig_q so anode and segments switch together.
  always_comb begin
    cur_digit = 4'd0;
    cur_on    = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_q == 3'(k)) begin
        cur_digit = digits_q[k];
`ifdef CODER_SCAN_BLANK_EN
        cur_on    = valid_q[k];
`endif
      end
    end
  end

  always_comb begin
    case (cur_digit)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end

  assign flag   = flag_q;
  assign ledout = ledout_q;
  assign count  = count_q;
  assign ssdout = cur_on ? seg : 7'b1111111;
  assign dp     = 1'b1;
  assign an     = ~(8'b0000_0001 << dig_q);

endmodule

// File: tb/tb_coder_scan.sv
// Table-driven bench for coder_scan: encoder vectors plus hand-written capture, clear, scan and reset sequences.
// Three instances (DIGITS 4, 3 and 8, SCAN_DIV 4) share one set of inputs.
module tb_coder_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       seltype;
  logic [9:0] din1;
  logic       clr;

  logic       flag4, flag3, flag8;
  logic [3:0] led4, led3, led8;
  logic [3:0] count4, count3, count8;
  logic [6:0] ssd4, ssd3, ssd8;
  logic       dp4, dp3, dp8;
  logic [7:0] an4, an3, an8;

  int checks = 0;
  int passes = 0;

  int presc, dig4, dig3;

`ifdef CODER_SCAN_BLANK_EN
  localparam logic [6:0] EXP_EMPTY = 7'b1111111;
`else
  localparam logic [6:0] EXP_EMPTY = 7'b1000000;
`endif

  typedef struct {
    logic       en;
    logic       sel;
    logic [9:0] din;
    logic       expFlag;
    logic [3:0] expLed;
  } vec_t;

  vec_t vecs[12];
  logic [7:0] anSeq[3];

  coder_scan #(.DIN_W(10), .DIGITS(4), .SCAN_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .seltype(seltype), .din1(din1), .clr(clr),
    .flag(flag4), .ledout(led4), .count(count4), .ssdout(ssd4), .dp(dp4), .an(an4));

  coder_scan #(.DIN_W(10), .DIGITS(3), .SCAN_DIV(4)) dut3 (
    .clk(clk), .rst(rst), .enable(enable), .seltype(seltype), .din1(din1), .clr(clr),
    .flag(flag3), .ledout(led3), .count(count3), .ssdout(ssd3), .dp(dp3), .an(an3));

  coder_scan #(.DIN_W(10), .DIGITS(8), .SCAN_DIV(4)) dut8 (
    .clk(clk), .rst(rst), .enable(enable), .seltype(seltype), .din1(din1), .clr(clr),
    .flag(flag8), .ledout(led8), .count(count8), .ssdout(ssd8), .dp(dp8), .an(an8));

  always #5 clk = ~clk;

  // Expected scan position: four clocks per digit, wrapping modulo the digit count.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= 0;
      dig4  <= 0;
      dig3  <= 0;
    end else if (presc == 3) begin
      presc <= 0;
      dig4  <= (dig4 == 3) ? 0 : dig4 + 1;
      dig3  <= (dig3 == 2) ? 0 : dig3 + 1;
    end else begin
      presc <= presc + 1;
    end
  end

  function automatic logic [6:0] segOf(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic sel, input logic [9:0] d, input logic c);
    enable  = en;
    seltype = sel;
    din1    = d;
    clr     = c;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic checkDigit4(input int k, input logic [6:0] expSeg, input string name);
    int n = 0;
    while (dig4 != k && n < 20) begin
      tick();
      n++;
    end
    if (dig4 != k) begin
      checks++;
      $display("[TB] FAIL %s: scan never reached digit %0d", name, k);
    end else begin
      checkOutput(name, ssd4, expSeg);
    end
  endtask

  task automatic checkDigit3(input int k, input logic [6:0] expSeg, input string name);
    int n = 0;
    while (dig3 != k && n < 20) begin
      tick();
      n++;
    end
    if (dig3 != k) begin
      checks++;
      $display("[TB] FAIL %s: scan never reached digit %0d", name, k);
    end else begin
      checkOutput(name, ssd3, expSeg);
    end
  endtask

  // One capture of code c; ledout changes while flag stays high to prove it does not recapture.
  task automatic pulse(input int c);
    applyStimulus(1'b1, 1'b1, 10'(1 << c), 1'b0);
    tick();
    din1 = 10'h001;
    tick();
    tick();
    tick();
    din1 = 10'h000;
    tick();
    tick();
  endtask

  task automatic clearAll();
    applyStimulus(1'b1, 1'b1, 10'h000, 1'b1);
    tick();
    clr = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 10'h025, 1'b1, 4'd5};
    vecs[1]  = '{1'b1, 1'b0, 10'h025, 1'b1, 4'd0};
    vecs[2]  = '{1'b0, 1'b1, 10'h3FF, 1'b0, 4'd0};
    vecs[3]  = '{1'b1, 1'b1, 10'h000, 1'b0, 4'd0};
    vecs[4]  = '{1'b1, 1'b1, 10'h200, 1'b1, 4'd9};
    vecs[5]  = '{1'b1, 1'b0, 10'h200, 1'b1, 4'd9};
    vecs[6]  = '{1'b1, 1'b0, 10'h3FF, 1'b1, 4'd0};
    vecs[7]  = '{1'b1, 1'b1, 10'h3FF, 1'b1, 4'd9};
    vecs[8]  = '{1'b1, 1'b0, 10'h0C8, 1'b1, 4'd3};
    vecs[9]  = '{1'b1, 1'b1, 10'h0C8, 1'b1, 4'd7};
    vecs[10] = '{1'b1, 1'b1, 10'h001, 1'b1, 4'd0};
    vecs[11] = '{1'b0, 1'b0, 10'h001, 1'b0, 4'd0};
    anSeq[0] = 8'hFE;
    anSeq[1] = 8'hFD;
    anSeq[2] = 8'hFB;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 10'h000, 1'b0);
    tick();
    tick();
    checkOutput("rst_flag", flag4, 1'b0);
    checkOutput("rst_ledout", led4, 4'd0);
    checkOutput("rst_count", count4, 4'd0);
    checkOutput("rst_an", an4, 8'hFE);
    checkOutput("rst_dp", dp4, 1'b1);
    checkOutput("rst_ssd", ssd4, EXP_EMPTY);
    rst = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].en, vecs[i].sel, vecs[i].din, 1'b0);
      tick();
      checkOutput($sformatf("vec%0d_flag", i), flag4, vecs[i].expFlag);
      checkOutput($sformatf("vec%0d_ledout", i), led4, vecs[i].expLed);
    end

    clearAll();
    checkOutput("clr_count", count4, 4'd0);
    for (int c = 1; c <= 9; c++) begin
      pulse(c);
      checkOutput($sformatf("pulse%0d_count", c), count4, (c < 4) ? c : 4);
    end
    checkDigit4(0, segOf(9), "buf_d0");
    checkDigit4(1, segOf(8), "buf_d1");
    checkDigit4(2, segOf(7), "buf_d2");
    checkDigit4(3, segOf(6), "buf_d3");
    checkOutput("buf_dp", dp4, 1'b1);

    // Clear arrives on the very edge that would capture code 2.
    clearAll();
    pulse(3);
    checkOutput("pre_clr_count", count4, 4'd1);
    applyStimulus(1'b1, 1'b1, 10'h004, 1'b0);
    tick();
    clr = 1'b1;
    tick();
    clr  = 1'b0;
    din1 = 10'h000;
    tick();
    tick();
    checkOutput("clrcap_count", count4, 4'd0);
    for (int k = 0; k < 4; k++) checkDigit4(k, EXP_EMPTY, $sformatf("clrcap_d%0d", k));

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      checkOutput($sformatf("scan_an_%0d", k), an3, anSeq[(k / 4) % 3]);
      if (k < 12) tick();
    end
    tick();
    pulse(5);
    checkOutput("blank_count", count3, 4'd1);
    checkDigit3(0, segOf(5), "blank_d0");
    checkDigit3(1, EXP_EMPTY, "blank_d1");
    checkDigit3(2, EXP_EMPTY, "blank_d2");

    clearAll();
    for (int c = 1; c <= 4; c++) pulse(c);
    applyStimulus(1'b1, 1'b1, 10'h008, 1'b0);
    tick();
    tick();
    checkOutput("mid_count", count8, 4'd5);
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_flag", flag8, 1'b0);
    checkOutput("mid_rst_ledout", led8, 4'd0);
    checkOutput("mid_rst_count", count8, 4'd0);
    checkOutput("mid_rst_an", an8, 8'hFE);
    checkOutput("mid_rst_dp", dp8, 1'b1);
    checkOutput("mid_rst_ssd", ssd8, EXP_EMPTY);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("held_flag", flag8, 1'b1);
    checkOutput("held_ledout", led8, 4'd3);
    checkOutput("held_count", count8, 4'd0);
    din1 = 10'h000;
    tick();
    tick();
    din1 = 10'h008;
    tick();
    tick();
    tick();
    checkOutput("rearm_count", count8, 4'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/coder_scan.md
CODER_SCAN -- requirements
Module: coder_scan

Interface
REQ-001 SHALL have parameter DIN_W, default 10: number of request lines, legal range 2..16.
REQ-002 SHALL have parameter DIGITS, default 8: captured-digit buffer depth and scanned digit count, legal range 1..8.
REQ-003 SHALL have parameter SCAN_DIV, default 100000: clock cycles each digit is lit, legal range 2 or more.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  encoder enable.
REQ-007 SHALL have port seltype  input  1  priority mode: 1 = highest set index wins, 0 = lowest set index wins.
REQ-008 SHALL have port din1  input  DIN_W  request lines.
REQ-009 SHALL have port clr  input  1  synchronous clear of the digit buffer.
REQ-010 SHALL have port flag  output  1  registered; a valid code is present.
REQ-011 SHALL have port ledout  output  4  registered encoded index.
REQ-012 SHALL have port count  output  4  number of valid digits in the buffer, 0..DIGITS.
REQ-013 SHALL have port ssdout  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-014 SHALL have port dp  output  1  decimal point, active-low.
REQ-015 SHALL have port an  output  8  digit anodes, active-low, one-hot.

Function
REQ-016 SHALL register flag=1 and ledout=encoded index one cycle after enable=1 with at least one din1 bit set; index is the highest set bit when seltype=1 and the lowest when seltype=0.
REQ-017 SHALL register flag=0 and ledout=0 when enable=0 or din1 is all zeros.
REQ-018 SHALL zero-extend the index to 4 bits.
REQ-019 SHALL detect a capture event on the cycle the registered flag is 1 and was 0 on the previous cycle.
REQ-020 SHALL, on a capture event, shift the buffer: the new ledout goes to digit 0 and digit k moves to digit k+1.
REQ-021 SHALL discard digit DIGITS-1 when the buffer is full; count saturates at DIGITS.
REQ-022 SHALL increment count by 1 per capture event while count<DIGITS.
REQ-023 SHALL not capture while flag stays 1, including when ledout changes; only a 0->1 transition captures.
REQ-024 SHALL, on clr=1, set every digit to 0 and count to 0 on the next edge.
REQ-025 SHALL give clr priority over a simultaneous capture event; that event is lost.
REQ-026 SHALL hold a scan prescaler that counts 0..SCAN_DIV-1 and wraps to 0.
REQ-027 SHALL advance the digit index at prescaler wrap, modulo DIGITS (DIGITS-1 -> 0).
REQ-028 SHALL drive an[i]=0 only for i equal to the digit index; all other bits, including i>=DIGITS, are 1.
REQ-029 SHALL decode the selected digit as hex 0..F to ssdout (for example 0 -> 1000000, 8 -> 0000000, F -> 0001110).
REQ-030 SHALL hold dp=1 (off) at all times.
REQ-031 SHALL change ssdout and an on the same clock edge, with no extra cycle of skew.

Reset
REQ-032 SHALL, while rst=1, immediately force: flag=0, ledout=0, count=0, all digits 0, prescaler=0, digit index=0, an=8'b1111_1110, dp=1.
REQ-033 SHALL, during reset, drive ssdout to the digit-0 reset display defined in REQ-036 and REQ-037.
REQ-034 SHALL abandon any capture or scan in progress when rst asserts mid-operation, leaving no partial shift.
REQ-035 SHALL not treat a flag already high at reset release as a capture event until flag returns to 0 and rises again; the first clock after release loads flag_prev from flag.

Configuration
REQ-036 SHALL, with CODER_SCAN_BLANK_EN defined, keep a valid bit per digit; digits at position >= count show ssdout=1111111 (blank), with the anode still scanned.
REQ-037 SHALL, without CODER_SCAN_BLANK_EN, have no valid bits; unwritten digits display 0 (1000000).

Verification
REQ-038 SHALL cover: DIN_W=10, seltype=1, enable=1, din1=10'b0000100101 -> flag=1, ledout=5 after one cycle; with seltype=0 -> ledout=0.
REQ-039 SHALL cover: enable=0, din1=10'h3FF -> flag=0, ledout=0; then din1=0 with enable=1 -> flag=0.
REQ-040 SHALL cover: DIGITS=4, nine 0->1 flag pulses with codes 1..9 -> count=4, digits 0..3 = 9,8,7,6; holding din1 between pulses adds no capture.
REQ-041 SHALL cover: clr and a capture event in the same cycle -> count=0, all digits 0.
REQ-042 SHALL cover: SCAN_DIV=4, DIGITS=3 -> an cycles FE, FD, FB, FE every 4 clocks; with BLANK_EN and count=1, digits 1-2 show 1111111.
REQ-043 SHALL cover: rst pulsed mid-scan with count=5 -> outputs take reset values immediately, with no capture afterwards while flag is held high.
